// File: rtl/enc_link_decoder.sv
// Receive side of the encoded link: buffers {any, code} pairs from the
// 8-to-3 encoder and expands the head entry back to a one-hot vector.
module enc_link_decoder #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [CW-1:0]             put_code,
   input  logic                      put_any,
   input  logic                      EN_put,
   output logic                      RDY_put,
   input  logic                      EN_get,
   output logic                      RDY_get,
   output logic [(1<<CW)-1:0]        get,
   output logic [$clog2(DEPTH):0]    mv_count,
   output logic                      mv_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   localparam int NL = 1 << CW;

   logic [CW:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [NW-1:0] count;
   logic          err;

   logic          do_put;
   logic          do_get;
   logic          bad_put;
   logic          bad_get;

   logic [CW:0]   head;
   logic          head_any;
   logic [CW-1:0] head_code;

   // Ready flags come from registered occupancy only, never from the strobes.
   assign RDY_put = (count != NW'(DEPTH));
   assign RDY_get = (count != '0);

   assign do_put  = EN_put && RDY_put;
   assign do_get  = EN_get && RDY_get;
   assign bad_put = EN_put && !RDY_put;
   assign bad_get = EN_get && !RDY_get;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wp <= '0;
      end else if (do_put) begin
         wp <= wp + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rp <= '0;
      end else if (do_get) begin
         rp <= rp + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         count <= '0;
      end else begin
         unique case ({do_put, do_get})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err <= 1'b0;
      end else if (bad_put || bad_get) begin
         err <= 1'b1;
      end
   end

   // Storage carries no reset; stale slots are never visible past RDY_get.
   always_ff @(posedge CLK) begin
      if (do_put) begin
         mem[wp] <= {put_any, put_code};
      end
   end

   assign head      = mem[rp];
   assign head_any  = head[CW];
   assign head_code = head[CW-1:0];

   always_comb begin
      get = '0;
      for (int i = 0; i < NL; i++) begin
         get[i] = RDY_get && head_any && (head_code == CW'(i));
      end
   end

   assign mv_count = count;
   assign mv_err   = err;

endmodule

// File: tb/tb_enc_link_decoder.sv
// Directed bench for enc_link_decoder: reset, pass-through, wrap,
// protocol errors, async reset and streaming throughput.
module tb_enc_link_decoder;

   logic       CLK;
   logic       RST_N;
   logic [2:0] put_code;
   logic       put_any;
   logic       EN_put;
   logic       RDY_put;
   logic       EN_get;
   logic       RDY_get;
   logic [7:0] get;
   logic [2:0] mv_count;
   logic       mv_err;

   int checks;
   int failures;

   enc_link_decoder #(.DEPTH(4), .CW(3)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .put_code (put_code),
      .put_any  (put_any),
      .EN_put   (EN_put),
      .RDY_put  (RDY_put),
      .EN_get   (EN_get),
      .RDY_get  (RDY_get),
      .get      (get),
      .mv_count (mv_count),
      .mv_err   (mv_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      EN_put   = 1'b0;
      EN_get   = 1'b0;
      put_any  = 1'b0;
      put_code = 3'd0;
   endtask

   task automatic put1(input logic a, input logic [2:0] c);
      put_any  = a;
      put_code = c;
      EN_put   = 1'b1;
      tick();
      EN_put   = 1'b0;
   endtask

   task automatic get1();
      EN_get = 1'b1;
      tick();
      EN_get = 1'b0;
   endtask

   task automatic test_reset();
      RST_N    = 1'b0;
      EN_get   = 1'b0;
      EN_put   = 1'b1;
      put_any  = 1'b1;
      put_code = 3'd3;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({RDY_put, RDY_get, get, mv_count, mv_err} !==
             {1'b1, 1'b0, 8'h00, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset cyc%0d: put=%b get_rdy=%b get=%h cnt=%0d err=%b want 1 0 00 0 0",
                     i, RDY_put, RDY_get, get, mv_count, mv_err);
         end
      end
      idle();
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_single_pass();
      put1(1'b1, 3'd5);
      checks++;
      if ({RDY_get, get, mv_count} !== {1'b1, 8'h20, 3'd1}) begin
         failures++;
         $display("FAIL single_put: rdy=%b get=%h cnt=%0d want 1 20 1",
                  RDY_get, get, mv_count);
      end
      get1();
      checks++;
      if ({RDY_get, get, mv_count} !== {1'b0, 8'h00, 3'd0}) begin
         failures++;
         $display("FAIL single_get: rdy=%b get=%h cnt=%0d want 0 00 0",
                  RDY_get, get, mv_count);
      end
   endtask

   task automatic test_fill_wrap();
      logic [7:0] exp [4];
      exp[0] = 8'h04;
      exp[1] = 8'h08;
      exp[2] = 8'h40;
      exp[3] = 8'h80;
      for (int i = 0; i < 4; i++) put1(1'b1, 3'(i));
      checks++;
      if ({RDY_put, mv_count, get} !== {1'b0, 3'd4, 8'h01}) begin
         failures++;
         $display("FAIL fill_full: rdy_put=%b cnt=%0d get=%h want 0 4 01",
                  RDY_put, mv_count, get);
      end
      get1();
      get1();
      put1(1'b1, 3'd6);
      put1(1'b1, 3'd7);
      checks++;
      if (mv_count !== 3'd4) begin
         failures++;
         $display("FAIL wrap_count: cnt=%0d want 4", mv_count);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (get !== exp[i]) begin
            failures++;
            $display("FAIL wrap_order%0d: get=%h want %h", i, get, exp[i]);
         end
         get1();
      end
      checks++;
      if ({RDY_get, mv_err} !== 2'b00) begin
         failures++;
         $display("FAIL wrap_end: rdy_get=%b err=%b want 0 0", RDY_get, mv_err);
      end
   endtask

   task automatic test_no_request();
      put1(1'b0, 3'd7);
      checks++;
      if ({RDY_get, get, mv_count} !== {1'b1, 8'h00, 3'd1}) begin
         failures++;
         $display("FAIL no_request: rdy=%b get=%h cnt=%0d want 1 00 1",
                  RDY_get, get, mv_count);
      end
      get1();
   endtask

   task automatic test_streaming();
      logic [7:0] want;
      put1(1'b1, 3'd0);
      for (int i = 1; i <= 32; i++) begin
         want = 8'h01 << ((i - 1) % 8);
         checks++;
         if (get !== want) begin
            failures++;
            $display("FAIL stream_data%0d: get=%h want %h", i, get, want);
         end
         put_any  = 1'b1;
         put_code = 3'(i % 8);
         EN_put   = 1'b1;
         EN_get   = 1'b1;
         tick();
         checks++;
         if (mv_count !== 3'd1) begin
            failures++;
            $display("FAIL stream_count%0d: cnt=%0d want 1", i, mv_count);
         end
      end
      idle();
      get1();
      checks++;
      if ({RDY_get, mv_err} !== 2'b00) begin
         failures++;
         $display("FAIL stream_end: rdy_get=%b err=%b want 0 0", RDY_get, mv_err);
      end
   endtask

   task automatic test_full_simul();
      logic [7:0] exp [3];
      exp[0] = 8'h04;
      exp[1] = 8'h08;
      exp[2] = 8'h10;
      for (int i = 1; i <= 4; i++) put1(1'b1, 3'(i));
      put_any  = 1'b1;
      put_code = 3'd7;
      EN_put   = 1'b1;
      EN_get   = 1'b1;
      tick();
      idle();
      checks++;
      if ({mv_count, get, mv_err} !== {3'd3, 8'h04, 1'b1}) begin
         failures++;
         $display("FAIL full_simul: cnt=%0d get=%h err=%b want 3 04 1",
                  mv_count, get, mv_err);
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (get !== exp[i]) begin
            failures++;
            $display("FAIL full_drain%0d: get=%h want %h", i, get, exp[i]);
         end
         get1();
      end
      checks++;
      if ({RDY_get, get, mv_err} !== {1'b0, 8'h00, 1'b1}) begin
         failures++;
         $display("FAIL full_end: rdy=%b get=%h err=%b want 0 00 1",
                  RDY_get, get, mv_err);
      end
      tick();
      checks++;
      if (mv_err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky: err=%b want 1", mv_err);
      end
   endtask

   task automatic test_async_reset();
      put1(1'b1, 3'd1);
      put1(1'b1, 3'd2);
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if ({RDY_put, RDY_get, get, mv_count, mv_err} !==
          {1'b1, 1'b0, 8'h00, 3'd0, 1'b0}) begin
         failures++;
         $display("FAIL async_reset: put=%b get_rdy=%b get=%h cnt=%0d err=%b want 1 0 00 0 0",
                  RDY_put, RDY_get, get, mv_count, mv_err);
      end
      tick();
      RST_N = 1'b1;
      tick();
   endtask

   task automatic test_empty_simul();
      put_any  = 1'b1;
      put_code = 3'd6;
      EN_put   = 1'b1;
      EN_get   = 1'b1;
      tick();
      idle();
      checks++;
      if ({mv_count, get, RDY_get, mv_err} !== {3'd1, 8'h40, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL empty_simul: cnt=%0d get=%h rdy=%b err=%b want 1 40 1 1",
                  mv_count, get, RDY_get, mv_err);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle();
      test_reset();
      test_single_pass();
      test_fill_wrap();
      test_no_request();
      test_streaming();
      test_full_simul();
      test_async_reset();
      test_empty_simul();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/enc_link_decoder.md
# enc_link_decoder

Receive-side stage of the encoded transmission link: it consumes the 3-bit code and "any request" flag produced by the 8-to-3 encoder, buffers them in a small FIFO, and expands each code back to an 8-line one-hot vector for the downstream consumer. The block decouples encoder output timing from consumer readiness using method-style EN/RDY handshakes on both sides. It reports occupancy and a sticky protocol-error flag.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- CW, 3, code width (fixed at 3; 2**CW = 8 output lines)
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  reset; asynchronous, active-low (asserting clears all state immediately, release is synchronised by the environment)
- put_code  in  3  encoded line index from encoder (out_a2..out_a0 packed, a2 = MSB)
- put_any  in  1  1 = code is valid (some enc_y line active); 0 = no line active
- EN_put  in  1  enqueue strobe, single-cycle per entry
- RDY_put  out  1  1 when FIFO not full
- EN_get  in  1  dequeue strobe
- RDY_get  out  1  1 when FIFO not empty
- get  out  8  decoded head entry: one-hot 1<<code if any=1, 8'h00 if any=0; 8'h00 when empty
- mv_count  out  clog2(DEPTH)+1  current occupancy 0..DEPTH
- mv_err  out  1  sticky protocol error

## Operation
- Storage: DEPTH entries of {any, code} (4 bits), write pointer wp, read pointer rp, each clog2(DEPTH) bits, wrap modulo DEPTH naturally; count register separate (not derived from pointers).
- Enqueue fires when EN_put && RDY_put: mem[wp] <= {put_any, put_code}, wp <= wp+1.
- Dequeue fires when EN_get && RDY_get: rp <= rp+1.
- Count: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither fire.
- RDY_put = (count != DEPTH); RDY_get = (count != 0). Both depend only on registered state, never on EN_put/EN_get (no combinational EN->RDY path).
- Full and EN_get and EN_put same cycle: dequeue fires, enqueue is rejected (RDY_put was 0); count becomes DEPTH-1; mv_err set.
- get is combinational from mem[rp] decode; head value changes only on dequeue or on enqueue into empty FIFO.
- Decode: bit i of get = any && (code == i); put_any=0 entries occupy a slot and are delivered as 8'h00 with RDY_get=1 (consumer distinguishes from empty via RDY_get).
- mv_err set on EN_put while RDY_put=0 or EN_get while RDY_get=0; clears only on reset. Rejected strobes do not change pointers, count, or memory.

## Timing
- Reset values: count 0, wp 0, rp 0, RDY_put 1, RDY_get 0, get 8'h00, mv_count 0, mv_err 0. Memory contents need not reset.
- Latency: enqueue at edge N -> RDY_get=1 and get valid after edge N (visible in cycle N+1). Zero bubble: one put and one get per cycle sustain throughput 1 with count constant.
- Dequeue at edge N -> next entry on get in cycle N+1; if last entry, get=8'h00 and RDY_get=0 in cycle N+1.
- Empty with EN_put and EN_get same cycle: only enqueue fires, count 0->1, mv_err set.
- RST_N asserted mid-operation: all outputs return to reset values asynchronously; in-flight entries discarded.

## Test plan
- Reset: hold RST_N=0 with EN_put=1, put_any=1, code=3 -> RDY_put=1, RDY_get=0, get=00, mv_count=0, mv_err=0 throughout.
- Single pass: put {1,3'd5} -> next cycle RDY_get=1, get=8'h20, mv_count=1; EN_get -> next cycle RDY_get=0, get=00, mv_count=0.
- Fill/wrap: put codes 0,1,2,3 (DEPTH=4) -> RDY_put=0, mv_count=4; get 2, put 6,7 -> gets return 8'h04,8'h08,8'h40,8'h80 in order, mv_err=0.
- No-request entry: put {0,3'd7} -> RDY_get=1, get=8'h00, mv_count=1.
- Full + simultaneous put/get: at count 4 assert both -> count 3, head advances, rejected code absent from later output, mv_err=1 and stays 1 until reset.
- Streaming: put and get every cycle for 32 cycles with codes 0..7 repeating -> mv_count constant 1, output sequence matches input one cycle late, mv_err=0.
